mc5_pwm_bridge: RTL and testbench

Sink end of the controller's motor-5 PWM stream. Accepts signed 16-bit duty commands over a valid/ready handshake, double-buffers them, and drives one H-bridge with a center-free, edge-aligned PWM carrier and programmable dead time. The block sits between the controller subsystem's `mc5_pwm`/`mc5_fault` outputs and the gate-driver pins. It applies brake and fault overrides with defined priority.

---
 rtl/mc5_pwm_bridge.sv | 170 +++++++++++++++++
 tb/tb_mc5_pwm_bridge.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc5_pwm_bridge.sv
// Motor-5 PWM sink: double-buffered signed duty driving one H-bridge with dead time.
// Optional period watchdog is built when MC5_PWM_WATCHDOG_EN is defined.
module mc5_pwm_bridge #(
  parameter int PERIOD      = 1000,
  parameter int DEADTIME    = 10,
  parameter int WDT_PERIODS = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pwm_data,
  input  logic        pwm_valid,
  output logic        pwm_ready,
  input  logic        fault,
  input  logic        brake,
  output logic        gate_ah,
  output logic        gate_al,
  output logic        gate_bh,
  output logic        gate_bl,
  output logic        wdt_timeout
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
  localparam logic [16:0] MAG_MAX = 17'(PERIOD);
  localparam logic [7:0] DT_LOAD = 8'(DEADTIME - 1);

  typedef enum logic [1:0] {OFF, HIGH, LOW, DEAD} leg_t;

  logic [CW-1:0] cnt;
  logic [15:0] active;
  logic [15:0] shadow;
  logic        pending;
  logic        wrap;
  logic        accept;
  logic        dir;
  logic        wdt_off;
  logic [16:0] ext;
  logic [16:0] absv;
  logic [16:0] mag;
  leg_t        lvl;
  leg_t        tgt [2];
  leg_t        state [2];
  leg_t        state_n [2];
  logic [7:0]  dt [2];
  logic [7:0]  dt_n [2];

  assign wrap = cnt == CNT_LAST;
  assign pwm_ready = !pending && !reset;
  assign accept = pwm_valid && pwm_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      active  <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      if (wrap && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end else if (accept && wrap) begin
        active <= pwm_data;
      end else if (accept) begin
        shadow  <= pwm_data;
        pending <= 1'b1;
      end
    end
  end

  // 17-bit magnitude so that -32768 maps to +32768
  assign dir  = active[15];
  assign ext  = {active[15], active};
  assign absv = dir ? 17'd0 - ext : ext;
  assign mag  = (absv > MAG_MAX) ? MAG_MAX : absv;

  always_comb begin
    lvl = (17'(cnt) < mag) ? HIGH : LOW;
    tgt[0] = dir ? LOW : lvl;
    tgt[1] = dir ? lvl : LOW;
    if (fault) begin
      tgt[0] = OFF;
      tgt[1] = OFF;
    end else if (brake) begin
      tgt[0] = LOW;
      tgt[1] = LOW;
    end else if (wdt_off) begin
      tgt[0] = OFF;
      tgt[1] = OFF;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_n[i] = state[i];
      dt_n[i]    = dt[i];
      if (tgt[i] == OFF) begin
        state_n[i] = OFF;
      end else begin
        unique case (state[i])
          OFF, HIGH, LOW: begin
            if (tgt[i] != state[i]) begin
              state_n[i] = DEAD;
              dt_n[i]    = DT_LOAD;
            end
          end
          DEAD: begin
            if (dt[i] == 8'd0) state_n[i] = tgt[i];
            else dt_n[i] = dt[i] - 8'd1;
          end
          default: state_n[i] = OFF;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state[0] <= OFF;
      state[1] <= OFF;
      dt[0]    <= '0;
      dt[1]    <= '0;
      gate_ah  <= 1'b0;
      gate_al  <= 1'b0;
      gate_bh  <= 1'b0;
      gate_bl  <= 1'b0;
    end else begin
      state   <= state_n;
      dt      <= dt_n;
      gate_ah <= state_n[0] == HIGH;
      gate_al <= state_n[0] == LOW;
      gate_bh <= state_n[1] == HIGH;
      gate_bl <= state_n[1] == LOW;
    end
  end

`ifdef MC5_PWM_WATCHDOG_EN
  localparam int WW = $clog2(WDT_PERIODS + 1);
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_PERIODS - 1);

  logic [WW-1:0] per_cnt;
  logic          wdt;

  // wdt_off outlives wdt so drive only resumes from the next wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      per_cnt <= '0;
      wdt     <= 1'b0;
      wdt_off <= 1'b0;
    end else if (accept) begin
      per_cnt <= '0;
      wdt     <= 1'b0;
      if (wrap) wdt_off <= 1'b0;
    end else if (wrap && !wdt) begin
      per_cnt <= per_cnt + WW'(1);
      wdt     <= per_cnt == WDT_LAST;
      wdt_off <= per_cnt == WDT_LAST;
    end
  end

  assign wdt_timeout = wdt;
`else
  assign wdt_off     = 1'b0;
  assign wdt_timeout = 1'b0;
`endif

  a_leg_a: assert property (@(posedge clk) !(gate_ah && gate_al));
  a_leg_b: assert property (@(posedge clk) !(gate_bh && gate_bl));

endmodule

// File: tb/tb_mc5_pwm_bridge.sv
// Bench for mc5_pwm_bridge: duty table with per-period gate counts plus
// hand sequences for back-pressure, fault, brake, reset and watchdog.
module tb_mc5_pwm_bridge;
  localparam int P = 100;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pwm_data = '0;
  logic        pwm_valid = 1'b0;
  logic        fault = 1'b0;
  logic        brake = 1'b0;
  logic        pwm_ready;
  logic        gate_ah;
  logic        gate_al;
  logic        gate_bh;
  logic        gate_bl;
  logic        wdt_timeout;

  int checks = 0;
  int failures = 0;
  int mcnt = 0;

  typedef struct {
    logic [15:0] duty;
    int ah;
    int al;
    int bh;
    int bl;
  } vec_t;

  vec_t vecs [9];
  vec_t q [$];

  mc5_pwm_bridge #(
    .PERIOD(P),
    .DEADTIME(D),
    .WDT_PERIODS(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pwm_data(pwm_data),
    .pwm_valid(pwm_valid),
    .pwm_ready(pwm_ready),
    .fault(fault),
    .brake(brake),
    .gate_ah(gate_ah),
    .gate_al(gate_al),
    .gate_bh(gate_bh),
    .gate_bl(gate_bl),
    .wdt_timeout(wdt_timeout)
  );

  always #5 clk = ~clk;

  // reference carrier position
  always @(posedge clk) begin
    if (reset) mcnt <= 0;
    else mcnt <= (mcnt == P - 1) ? 0 : mcnt + 1;
  end

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if ((gate_ah && gate_al) || (gate_bh && gate_bl)) begin
        failures++;
        $display("FAIL shoot_through ah=%0b al=%0b bh=%0b bl=%0b",
                 gate_ah, gate_al, gate_bh, gate_bl);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  function automatic int gates();
    return int'({gate_ah, gate_al, gate_bh, gate_bl});
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_cnt(input int c);
    int n;
    n = 0;
    @(negedge clk);
    while (mcnt != c && n < 250) begin
      @(negedge clk);
      n++;
    end
    if (mcnt != c) chk("wait_cnt_timeout", mcnt, c);
  endtask

  task automatic send(input logic [15:0] d);
    int n;
    n = 0;
    @(negedge clk);
    pwm_data = d;
    pwm_valid = 1'b1;
    while (!pwm_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!pwm_ready) chk("send_timeout", int'(pwm_ready), 1);
    @(posedge clk);
    #1;
    pwm_valid = 1'b0;
  endtask

  task automatic measure(output int ah, output int al,
                         output int bh, output int bl);
    ah = 0; al = 0; bh = 0; bl = 0;
    for (int i = 0; i < P; i++) begin
      if (i > 0) @(negedge clk);
      ah += int'(gate_ah);
      al += int'(gate_al);
      bh += int'(gate_bh);
      bl += int'(gate_bl);
    end
  endtask

  initial begin
    int ah, al, bh, bl, on, n;
    vec_t e;

    vecs[0] = '{16'd40,   36,  56,   0, 100};
    vecs[1] = '{16'h8000,  0, 100, 100,   0};
    vecs[2] = '{16'd50,   46,  46,   0, 100};
    vecs[3] = '{16'hFFE7,  0, 100,  21,  71};
    vecs[4] = '{16'd0,     0, 100,   0, 100};
    vecs[5] = '{16'd100, 100,   0,   0, 100};
    vecs[6] = '{16'd200, 100,   0,   0, 100};
    vecs[7] = '{16'hFFC4,  0, 100,  56,  36};
    vecs[8] = '{16'd10,    6,  86,   0, 100};

    repeat (3) @(negedge clk);
    chk("rst_gates", gates(), 0);
    chk("rst_ready", int'(pwm_ready), 0);
    chk("rst_wdt", int'(wdt_timeout), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rel_ready", int'(pwm_ready), 1);
    chk("rel_active", int'(dut.active), 0);

    foreach (vecs[i]) begin
      q.push_back(vecs[i]);
      send(vecs[i].duty);
      wait_cnt(0);
      wait_cnt(0);
      measure(ah, al, bh, bl);
      e = q.pop_front();
      chk($sformatf("v%0d_ah", i), ah, e.ah);
      chk($sformatf("v%0d_al", i), al, e.al);
      chk($sformatf("v%0d_bh", i), bh, e.bh);
      chk($sformatf("v%0d_bl", i), bl, e.bl);
    end

    wait_cnt(30);
    send(16'd30);
    chk("bp_ready_low", int'(pwm_ready), 0);
    @(negedge clk);
    pwm_data = 16'd70;
    pwm_valid = 1'b1;
    n = 0;
    while (!pwm_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("bp_ready_cnt", mcnt, 0);
    chk("bp_active_first", int'(dut.active), 30);
    @(posedge clk);
    #1;
    pwm_valid = 1'b0;
    wait_cnt(0);
    chk("bp_active_second", int'(dut.active), 70);

    send(16'd50);
    wait_cnt(0);
    wait_cnt(0);
    wait_cnt(20);
    chk("flt_pre_ah", int'(gate_ah), 1);
    fault = 1'b1;
    @(negedge clk);
    chk("flt_off", gates(), 0);
    repeat (9) @(negedge clk);
    fault = 1'b0;
    on = 0;
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      on += (gates() != 0) ? 1 : 0;
    end
    chk("flt_dead", on, 0);
    @(negedge clk);
    chk("flt_resume", gates(), 4'b1001);

    wait_cnt(40);
    chk("brk_pre_ah", int'(gate_ah), 1);
    brake = 1'b1;
    @(negedge clk);
    chk("brk_ah_drop", gates(), 4'b0001);
    on = 0;
    for (int i = 0; i < D - 1; i++) begin
      @(negedge clk);
      on += int'(gate_al);
    end
    chk("brk_dead", on, 0);
    @(negedge clk);
    chk("brk_low", gates(), 4'b0101);
    brake = 1'b0;

    wait_cnt(60);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_gates", gates(), 0);
    chk("mid_rst_ready", int'(pwm_ready), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rel_ready", int'(pwm_ready), 1);
    chk("mid_rel_active", int'(dut.active), 0);
    wait_cnt(0);
    chk("mid_rel_gates", gates(), 4'b0101);

`ifdef MC5_PWM_WATCHDOG_EN
    wait_cnt(0);
    wait_cnt(0);
    wait_cnt(2);
    chk("wdt_set", int'(wdt_timeout), 1);
    chk("wdt_gates", gates(), 0);
    send(16'd20);
    chk("wdt_clear", int'(wdt_timeout), 0);
    wait_cnt(50);
    chk("wdt_hold_off", gates(), 0);
    wait_cnt(4);
    chk("wdt_dead", gates(), 0);
    @(negedge clk);
    chk("wdt_resume", gates(), 4'b1001);
`else
    wait_cnt(0);
    wait_cnt(0);
    wait_cnt(10);
    chk("wdt_tied", int'(wdt_timeout), 0);
    chk("wdt_hold_duty", gates(), 4'b0101);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
